// File: rtl/hazard_pkg.sv
// Shared entry type and sizing helpers for the data-hazard / forwarding unit.
package hazard_pkg;

  // Tags are stored at a fixed width so the entry type can live in the package;
  // narrower register indices are zero-extended on insertion and comparison.
  localparam int unsigned HZ_TAG_W = 8;

  typedef struct packed {
    logic                valid;
    logic [HZ_TAG_W-1:0] dst;
    logic                load;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = '{valid: 1'b0, dst: '0, load: 1'b0};

  function automatic int unsigned sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Youngest-producer priority encoder for one ID source operand.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SEL_W = 2
) (
  input  hz_entry_t [DEPTH:1] entries,
  input  logic [REG_W-1:0]    src,
  input  logic                used,
  output logic [SEL_W-1:0]    sel,
  output logic                is_load_hit
);

  logic [HZ_TAG_W-1:0] tag;

  assign tag = HZ_TAG_W'(src);

  // Scan oldest to youngest so the smallest matching stage index wins.
  always_comb begin
    sel         = '0;
    is_load_hit = 1'b0;
    if (used && (src != '0)) begin
      for (int unsigned k = DEPTH; k >= 1; k--) begin
        if (entries[k].valid && (entries[k].dst == tag)) begin
          sel         = SEL_W'(k);
          is_load_hit = entries[k].load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Data-hazard detector and forwarding-select generator beside the ID stage;
// tracks in-flight destination tags and raises load-use stalls.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              flush,
  input  logic                              id_valid,
  input  logic [NUM_SRC*REG_W-1:0]          id_src,
  input  logic [NUM_SRC-1:0]                id_src_used,
  input  logic [REG_W-1:0]                  id_dst,
  input  logic                              id_wen,
  input  logic                              id_load,
  output logic [NUM_SRC*sel_w(DEPTH)-1:0]   fwd_sel,
  output logic                              stall,
  output logic [CNT_W-1:0]                  stall_cnt
);

  localparam int unsigned SEL_W = sel_w(DEPTH);

  hz_entry_t [DEPTH:1]  ent_q;
  hz_entry_t            ins_entry;
  logic [SEL_W-1:0]     src_sel [NUM_SRC];
  logic [NUM_SRC-1:0]   load_hit;
  logic [NUM_SRC-1:0]   hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .REG_W (REG_W),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .entries     (ent_q),
      .src         (id_src[i*REG_W +: REG_W]),
      .used        (id_src_used[i]),
      .sel         (src_sel[i]),
      .is_load_hit (load_hit[i])
    );

    assign fwd_sel[i*SEL_W +: SEL_W] = src_sel[i];
    // A load producer is only forwardable once it reaches LOAD_READY.
    assign hazard[i] = load_hit[i] && (32'(src_sel[i]) < LOAD_READY);
  end

  assign stall = id_valid && !flush && (|hazard);

  always_comb begin
    ins_entry = HZ_BUBBLE;
    if (id_valid && !flush && !stall) begin
      ins_entry = '{valid: id_wen && (id_dst != '0),
                    dst:   HZ_TAG_W'(id_dst),
                    load:  id_load};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else if (en) begin
      ent_q[1] <= ins_entry;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        ent_q[k] <= ent_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (en && stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
